// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: read-back receiver for a multiplexed 7-segment display.
// Waits for each scan slot to settle, decodes the segment pattern back to a
// hex code, gathers one value per digit into a frame, and hands complete
// frames to a consumer over a valid/ready handshake.
module seg7_scan_capture #(
  parameter int DIGITS = 2,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic [6:0]            seg_in,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
);

  localparam int IW = DIGITS + 7;
  localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(STABLE - 1);

  logic [IW-1:0]       r_cur;
  logic [IW-1:0]       r_prev;
  logic [CW-1:0]       r_cnt;
  logic                r_sampled;
  logic [DIGITS-1:0]   r_captured;
  logic [4*DIGITS-1:0] r_slot_data;
  logic [DIGITS-1:0]   r_slot_err;
  logic [4*DIGITS-1:0] r_frame_data;
  logic [DIGITS-1:0]   r_frame_err;
  logic                r_frame_valid;
  logic                r_overrun;

  logic [DIGITS-1:0]   w_dig;
  logic [6:0]          w_seg;
  logic                w_change;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_sampled_eff;
  logic                w_onehot;
  logic                w_sample;
  logic [3:0]          w_code;
  logic                w_bad;
  logic [DIGITS-1:0]   w_cap_nxt;
  logic [4*DIGITS-1:0] w_slot_data_nxt;
  logic [DIGITS-1:0]   w_slot_err_nxt;
  logic                w_complete;
  logic                w_load;

  assign w_dig    = r_cur[IW-1:7];
  assign w_seg    = r_cur[6:0];
  assign w_change = (r_cur != r_prev);

  // The counter and sampled flag are evaluated on their next values so that a
  // value registered at edge N is sampled exactly STABLE edges later.
  assign w_cnt_nxt     = w_change ? '0 : ((r_cnt == CNT_TOP) ? r_cnt : r_cnt + CW'(1));
  assign w_sampled_eff = w_change ? 1'b0 : r_sampled;
  assign w_onehot      = (w_dig != '0) && ((w_dig & (w_dig - DIGITS'(1))) == '0);
  assign w_sample      = (w_cnt_nxt == CNT_TOP) && !w_sampled_eff && w_onehot;

  // Segment pattern back to hex code; anything unrecognised is flagged.
  always_comb begin
    w_code = 4'h0;
    w_bad  = 1'b0;
    case (w_seg)
      7'h7E: w_code = 4'h0;
      7'h30: w_code = 4'h1;
      7'h6D: w_code = 4'h2;
      7'h79: w_code = 4'h3;
      7'h33: w_code = 4'h4;
      7'h5B: w_code = 4'h5;
      7'h5F: w_code = 4'h6;
      7'h70: w_code = 4'h7;
      7'h7F: w_code = 4'h8;
      7'h7B: w_code = 4'h9;
      7'h77: w_code = 4'hA;
      7'h1F: w_code = 4'hB;
      7'h4E: w_code = 4'hC;
      7'h3D: w_code = 4'hD;
      7'h4F: w_code = 4'hE;
      7'h47: w_code = 4'hF;
      default: begin
        w_code = 4'h0;
        w_bad  = 1'b1;
      end
    endcase
  end

  // Merge a fresh sample into its slot; the latest sample of a digit wins.
  always_comb begin
    w_slot_data_nxt = r_slot_data;
    w_slot_err_nxt  = r_slot_err;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_sample && w_dig[i]) begin
        w_slot_data_nxt[4*i +: 4] = w_code;
        w_slot_err_nxt[i]         = w_bad;
      end
    end
  end

  assign w_cap_nxt  = r_captured | (w_sample ? w_dig : '0);
  assign w_complete = w_sample && (&w_cap_nxt);
  assign w_load     = w_complete && (!r_frame_valid || frame_ready);

  // Input register and its one-cycle-old copy for change detection.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cur  <= '0;
      r_prev <= '0;
    end else begin
      r_cur  <= {dig_en, seg_in};
      r_prev <= r_cur;
    end
  end

  // Stability counter and the one-sample-per-interval flag.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cnt     <= '0;
      r_sampled <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_sampled <= w_sample ? 1'b1 : w_sampled_eff;
    end
  end

  // Per-slot capture state; a completed frame always empties the mask.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_captured  <= '0;
      r_slot_data <= '0;
      r_slot_err  <= '0;
    end else begin
      r_captured  <= w_complete ? '0 : w_cap_nxt;
      r_slot_data <= w_slot_data_nxt;
      r_slot_err  <= w_slot_err_nxt;
    end
  end

  // Output frame registers, handshake and sticky overrun.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_frame_data  <= '0;
      r_frame_err   <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_load) begin
        r_frame_data  <= w_slot_data_nxt;
        r_frame_err   <= w_slot_err_nxt;
        r_frame_valid <= 1'b1;
      end else if (r_frame_valid && frame_ready) begin
        r_frame_valid <= 1'b0;
      end
      if (w_complete && !w_load) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_err   = r_frame_err;
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (DIGITS=2, STABLE=4) with a frame
// scoreboard: expected frames are queued as scans are driven and checked
// when the DUT transfers them.
module tb_seg7_scan_capture;

  logic       clk;
  logic       clr_n;
  logic [1:0] dig_en;
  logic [6:0] seg_in;
  logic [7:0] frame_data;
  logic [1:0] frame_err;
  logic       frame_valid;
  logic       frame_ready;
  logic       overrun;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] e;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_frames = 0;

  seg7_scan_capture #(.DIGITS(2), .STABLE(4)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .dig_en     (dig_en),
    .seg_in     (seg_in),
    .frame_data (frame_data),
    .frame_err  (frame_err),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Score any transfer the next rising edge will perform, then advance.
  task automatic tick();
    exp_t e;
    if (frame_valid && frame_ready) begin
      n_frames++;
      n_tests++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_frame observed=%0h expected=none", {frame_data, frame_err});
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("frame_data", 32'(frame_data), 32'(e.d));
        check("frame_err", 32'(frame_err), 32'(e.e));
      end
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic [1:0] d, input logic [6:0] s, input int n);
    dig_en = d;
    seg_in = s;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clr_n       = 1'b0;
    dig_en      = '0;
    seg_in      = '0;
    frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_data", 32'(frame_data), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    clr_n = 1'b1;
    tick();

    // Basic scan: 1 then 2.
    frame_ready = 1'b1;
    sb.push_back('{d: 8'h21, e: 2'b00});
    hold(2'b01, 7'h30, 6);
    hold(2'b10, 7'h6D, 6);
    check("t1_frames", 32'(n_frames), 32'd1);
    check("t1_valid_dropped", 32'(frame_valid), 32'd0);

    // Short glitch (3 cycles) is ignored; exactly STABLE cycles is sampled.
    sb.push_back('{d: 8'h05, e: 2'b00});
    hold(2'b01, 7'h79, 3);
    hold(2'b01, 7'h5B, 4);
    hold(2'b10, 7'h7E, 6);
    check("t2_frames", 32'(n_frames), 32'd2);

    // Illegal pattern on digit 0.
    sb.push_back('{d: 8'h80, e: 2'b01});
    hold(2'b01, 7'h00, 6);
    hold(2'b10, 7'h7F, 6);
    check("t3_frames", 32'(n_frames), 32'd3);
    check("t3_overrun", 32'(overrun), 32'd0);

    // Back-pressure: second frame is dropped, first held.
    frame_ready = 1'b0;
    sb.push_back('{d: 8'h10, e: 2'b00});
    hold(2'b01, 7'h7E, 6);
    hold(2'b10, 7'h30, 6);
    check("t4_valid_first", 32'(frame_valid), 32'd1);
    check("t4_data_first", 32'(frame_data), 32'h10);
    check("t4_overrun_before", 32'(overrun), 32'd0);
    hold(2'b01, 7'h6D, 6);
    hold(2'b10, 7'h79, 6);
    check("t4_valid_held", 32'(frame_valid), 32'd1);
    check("t4_data_held", 32'(frame_data), 32'h10);
    check("t4_err_held", 32'(frame_err), 32'd0);
    check("t4_overrun", 32'(overrun), 32'd1);
    frame_ready = 1'b1;
    tick();
    check("t4_valid_drop", 32'(frame_valid), 32'd0);
    check("t4_frames", 32'(n_frames), 32'd4);

    // Multi-hot and blank enables never sample.
    hold(2'b11, 7'h30, 10);
    hold(2'b00, 7'h00, 6);
    check("t5_valid", 32'(frame_valid), 32'd0);
    check("t5_frames", 32'(n_frames), 32'd4);

    // Reset mid-scan discards the partial frame and clears overrun.
    hold(2'b01, 7'h33, 6);
    clr_n  = 1'b0;
    dig_en = 2'b00;
    seg_in = 7'h00;
    tick();
    tick();
    check("t6_rst_overrun", 32'(overrun), 32'd0);
    check("t6_rst_valid", 32'(frame_valid), 32'd0);
    check("t6_rst_data", 32'(frame_data), 32'd0);
    clr_n = 1'b1;
    hold(2'b10, 7'h5B, 6);
    hold(2'b00, 7'h00, 4);
    check("t6_no_frame_valid", 32'(frame_valid), 32'd0);
    check("t6_no_frame_count", 32'(n_frames), 32'd4);
    sb.push_back('{d: 8'h56, e: 2'b00});
    hold(2'b01, 7'h5F, 6);
    hold(2'b00, 7'h00, 4);
    check("t6_frames", 32'(n_frames), 32'd5);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
